// File: rtl/ccl_window_if.sv
// ccl_window_if: pixel stream in, labelled neighbourhood out, labeller feedback.
interface ccl_window_if #(parameter int WORD_SIZE = 8);
   logic                 in_valid;
   logic [WORD_SIZE-1:0] pixel_in;
   logic [WORD_SIZE-1:0] threshold;
   logic [WORD_SIZE-1:0] label_in;
   logic                 en;
   logic                 frame_done;
   logic [WORD_SIZE-1:0] p;
   logic [WORD_SIZE-1:0] A;
   logic [WORD_SIZE-1:0] B;
   logic [WORD_SIZE-1:0] C;
   logic [WORD_SIZE-1:0] D;
   logic [31:0]          x;
   logic [31:0]          y;
   modport master (output in_valid, pixel_in, threshold, label_in,
                   input en, frame_done, p, A, B, C, D, x, y);
   modport slave  (input in_valid, pixel_in, threshold, label_in,
                   output en, frame_done, p, A, B, C, D, x, y);
endinterface

// File: rtl/ccl_window.sv
// ccl_window: binarises the pixel stream and presents each pixel with its labelled
// neighbours, keeping one row of label history fed back from the labeller.
module ccl_window #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int WORD_SIZE  = 8
) (
   input logic         clk,
   input logic         reset_n,
   ccl_window_if.slave s
);
   logic                 en, en_d, frame_done;
   logic [WORD_SIZE-1:0] p;
   logic [31:0]          x, y, cx, cy;
   logic [WORD_SIZE-1:0] hist [0:IMG_WIDTH];
   logic                 row_end, last;
   logic                 top, left, right;
   assign row_end = cx == IMG_WIDTH - 1;
   assign last    = row_end && cy == IMG_HEIGHT - 1;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         en         <= 1'b0;
         en_d       <= 1'b0;
         frame_done <= 1'b0;
         p          <= '0;
         x          <= '0;
         y          <= '0;
         cx         <= '0;
         cy         <= '0;
         hist       <= '{default: '0};
      end else begin
         en         <= s.in_valid;
         en_d       <= en;
         frame_done <= s.in_valid && last;
         if (s.in_valid) begin
            p  <= WORD_SIZE'(s.pixel_in >= s.threshold);
            x  <= cx;
            y  <= cy;
            cx <= row_end ? '0 : cx + 32'd1;
            cy <= last ? '0 : row_end ? cy + 32'd1 : cy;
         end
         // label_in is valid exactly on the cycle after en, so it is captured once
         if (en_d) begin
            hist[0] <= s.label_in;
            for (int i = 1; i <= IMG_WIDTH; i++) hist[i] <= hist[i-1];
         end
      end
   end
   assign top   = en && y != 0;
   assign left  = x != 0;
   assign right = x != IMG_WIDTH - 1;
   // with en_d high the left neighbour is still on label_in, so the row taps shift down by one
   assign s.A = (top && left)  ? (en_d ? hist[IMG_WIDTH-1] : hist[IMG_WIDTH])   : '0;
   assign s.B = top            ? (en_d ? hist[IMG_WIDTH-2] : hist[IMG_WIDTH-1]) : '0;
   assign s.C = (top && right) ? (en_d ? hist[IMG_WIDTH-3] : hist[IMG_WIDTH-2]) : '0;
   assign s.D = (en && left)   ? (en_d ? s.label_in        : hist[0])           : '0;
   assign s.en         = en;
   assign s.frame_done = frame_done;
   assign s.p          = p;
   assign s.x          = x;
   assign s.y          = y;
endmodule

// File: tb/tb_ccl_window.sv
// tb_ccl_window: random pixels and labels checked against a coordinate-indexed label map.
module tb_ccl_window;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int WS = 8;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;
   ccl_window_if #(.WORD_SIZE(WS)) bus ();
   ccl_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .WORD_SIZE(WS)) dut (
      .clk(clk), .reset_n(reset_n), .s(bus)
   );
   int checks = 0;
   int failures = 0;
   int idx = 0;
   int ex = 0, ey = 0, px = 0, py = 0;
   bit exp_p = 0, prev_en = 0;
   int done_seen = 0, done_exp = 0;
   logic [WS-1:0] lab [H][W];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(bit v, logic [WS-1:0] pix, logic [WS-1:0] thr);
      logic [WS-1:0] ea, eb, ec, ed;
      bit fd;
      bus.in_valid  = v;
      bus.pixel_in  = pix;
      bus.threshold = thr;
      @(posedge clk);
      #1;
      bus.label_in = prev_en ? lab[py][px] : WS'($urandom);
      if (v) begin
         ex    = idx % W;
         ey    = idx / W;
         idx   = (idx + 1) % (W * H);
         exp_p = pix >= thr;
         lab[ey][ex] = WS'($urandom_range(1, 255));
      end
      ea = '0; eb = '0; ec = '0; ed = '0;
      if (v && ey > 0) begin
         eb = lab[ey-1][ex];
         if (ex > 0) ea = lab[ey-1][ex-1];
         if (ex < W - 1) ec = lab[ey-1][ex+1];
      end
      if (v && ex > 0) ed = lab[ey][ex-1];
      fd = v && ex == W - 1 && ey == H - 1;
      if (fd) done_exp++;
      #1;
      if (bus.frame_done) done_seen++;
      chk("en", 32'(bus.en), 32'(v));
      chk("p", 32'(bus.p), 32'(exp_p));
      chk("x", bus.x, 32'(ex));
      chk("y", bus.y, 32'(ey));
      chk("frame_done", 32'(bus.frame_done), 32'(fd));
      chk("A", 32'(bus.A), 32'(ea));
      chk("B", 32'(bus.B), 32'(eb));
      chk("C", 32'(bus.C), 32'(ec));
      chk("D", 32'(bus.D), 32'(ed));
      prev_en = v;
      px = ex;
      py = ey;
   endtask

   task automatic do_reset(int n);
      reset_n = 1'b0;
      bus.in_valid = 1'($urandom);
      bus.pixel_in = WS'($urandom);
      bus.threshold = WS'($urandom);
      repeat (n) @(posedge clk);
      #1;
      reset_n = 1'b1;
      bus.in_valid = 1'b0;
      bus.label_in = WS'($urandom);
      #1;
      idx = 0; ex = 0; ey = 0; exp_p = 0; prev_en = 0;
      chk("rst_en", 32'(bus.en), 32'd0);
      chk("rst_p", 32'(bus.p), 32'd0);
      chk("rst_x", bus.x, 32'd0);
      chk("rst_y", bus.y, 32'd0);
      chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
      chk("rst_nbr", 32'({bus.A, bus.B, bus.C, bus.D}), 32'd0);
   endtask

   task automatic gap_pixel(logic [WS-1:0] pix, logic [WS-1:0] thr);
      repeat ($urandom_range(0, 3)) step(1'b0, WS'($urandom), WS'($urandom));
      step(1'b1, pix, thr);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.pixel_in = '0;
      bus.threshold = '0;
      bus.label_in = '0;
      do_reset(2);
      for (int i = 0; i < W * H; i++) step(1'b1, 8'h00, 8'h01);
      for (int i = 0; i < W * H; i++) step(1'b1, 8'hFF, WS'($urandom));
      step(1'b1, 8'h7F, 8'h80);
      step(1'b1, 8'h80, 8'h80);
      for (int i = 2; i < 3 * W * H; i++) gap_pixel(WS'($urandom), WS'($urandom));
      while (!(ex == 3 && ey == 2)) step(1'b1, WS'($urandom), WS'($urandom));
      do_reset(1);
      for (int i = 0; i < 2 * W * H; i++) gap_pixel(WS'($urandom), WS'($urandom));
      repeat (4) step(1'b0, WS'($urandom), WS'($urandom));
      chk("frame_done_count", 32'(done_seen), 32'(done_exp));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
